// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the boot/monitor port and the CPU.
package dmem_arb_pkg;

    localparam int DMEM_ARB_STARVE_MAX = 8;
    localparam int DMEM_ARB_AW         = 32;
    localparam int DMEM_ARB_STAT_W     = 16;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        FORCE   = 2'd3
    } arb_state_e;

    function automatic logic [DMEM_ARB_STAT_W-1:0] sat_inc(input logic [DMEM_ARB_STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive deferred external cycles; done_o fires on the cycle that reaches MAX.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX = DMEM_ARB_STARVE_MAX
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic done_o
);

    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looks at the incoming increment so the FSM leaves RUN right after the MAX-th deferral.
    assign done_o = inc_i && !clr_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: external loader owns the port during boot, CPU has priority afterwards
// with starvation forcing. Optional statistics counters enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DMEM_ARB_STARVE_MAX,
    parameter int AW         = DMEM_ARB_AW
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          ext_valid_i,
    input  logic          ext_we_i,
    input  logic [AW-1:0] ext_addr_i,
    input  logic [AW-1:0] ext_wdata_i,
    output logic          ext_ready_o,
    output logic [AW-1:0] ext_rdata_o,
    output logic          ext_rvalid_o,
    input  logic          boot_done_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [AW-1:0] cpu_wdata_i,
    output logic          cpu_hold_o,
    output logic          cpu_stall_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [AW-1:0] mem_wdata_o,
    input  logic [AW-1:0] mem_rdata_i,
    output logic [15:0]   grant_cnt_o,
    output logic [15:0]   force_cnt_o
);

    arb_state_e    state_q;
    logic          cpu_hold_q, cpu_stall_q;
    logic          ext_rvalid_q;
    logic [AW-1:0] ext_rdata_q;
    logic          ext_gnt, cpu_gnt;
    logic          starve_inc, starve_clr, starve_done;

    // Grants are qualified by reset so nothing reaches the memory while reset is low.
    always_comb begin
        ext_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (reset_ni) begin
            case (state_q)
                BOOT:    ext_gnt = ext_valid_i;
                RELEASE: ext_gnt = 1'b0;
                RUN: begin
                    cpu_gnt = cpu_req_i;
                    ext_gnt = ext_valid_i && !cpu_req_i;
                end
                FORCE:   ext_gnt = ext_valid_i;
                default: ext_gnt = 1'b0;
            endcase
        end
    end

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        if (ext_gnt) begin
            mem_we_o    = ext_we_i;
            mem_addr_o  = ext_addr_i;
            mem_wdata_o = ext_wdata_i;
        end else if (cpu_gnt) begin
            mem_we_o = cpu_we_i;
        end
    end

    assign starve_inc = (state_q == RUN) && ext_valid_i && cpu_req_i;
    assign starve_clr = (state_q != RUN) || !ext_valid_i || ext_gnt;

    dmem_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (starve_inc),
        .clr_i    (starve_clr),
        .done_o   (starve_done)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= BOOT;
            cpu_hold_q  <= 1'b1;
            cpu_stall_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    if (boot_done_i) state_q <= RELEASE;
                end
                RELEASE: begin
                    state_q    <= RUN;
                    cpu_hold_q <= 1'b0;
                end
                RUN: begin
                    if (starve_done) begin
                        state_q     <= FORCE;
                        cpu_stall_q <= 1'b1;
                    end
                end
                FORCE: begin
                    state_q     <= RUN;
                    cpu_stall_q <= 1'b0;
                end
                default: begin
                    state_q     <= BOOT;
                    cpu_hold_q  <= 1'b1;
                    cpu_stall_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            ext_rvalid_q <= ext_gnt && !ext_we_i;
            if (ext_gnt && !ext_we_i) ext_rdata_q <= mem_rdata_i;
        end
    end

    assign ext_ready_o  = ext_gnt;
    assign ext_rvalid_o = ext_rvalid_q;
    assign ext_rdata_o  = ext_rdata_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign cpu_stall_o  = cpu_stall_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic [15:0] force_cnt_q, force_cnt_d;

    always_comb begin
        grant_cnt_d = ext_gnt ? sat_inc(grant_cnt_q) : grant_cnt_q;
        force_cnt_d = ((state_q == RUN) && starve_done) ? sat_inc(force_cnt_q) : force_cnt_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            grant_cnt_q <= '0;
            force_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            force_cnt_q <= force_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign force_cnt_o = force_cnt_q;
`else
    assign grant_cnt_o = '0;
    assign force_cnt_o = '0;
`endif

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 8: number of RUN-state cycles an external request may be deferred before it is forced.
REQ-002 Parameter AW, default 32: address and data width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ext_valid  in  1  external loader/monitor request.
REQ-006 ext_we  in  1  external request is a write (1) or a read (0).
REQ-007 ext_addr, ext_wdata  in  AW  external address and write data.
REQ-008 ext_ready  out  1  external request granted this cycle.
REQ-009 ext_rdata  out  AW  registered read data for the last granted external read.
REQ-010 ext_rvalid  out  1  one-cycle pulse qualifying ext_rdata.
REQ-011 boot_done  in  1  loader has finished writing the program image.
REQ-012 cpu_req  in  1  CPU issues a load or store this cycle.
REQ-013 cpu_we, cpu_addr, cpu_wdata  in  1/AW/AW  CPU data-memory access.
REQ-014 cpu_hold  out  1  keeps the CPU in reset while booting.
REQ-015 cpu_stall  out  1  freezes CPU PC/register writeback for one cycle.
REQ-016 mem_we, mem_addr, mem_wdata  out  1/AW/AW  data-memory port; mem_rdata  in  AW  combinational read data.
REQ-017 grant_cnt, force_cnt  out  16  statistics counters (see Configuration).

Function
REQ-018 The FSM SHALL have states BOOT, RELEASE, RUN and FORCE.
REQ-019 In BOOT, cpu_hold SHALL be 1, ext_ready SHALL equal ext_valid, and the memory port SHALL carry the ext_* signals.
REQ-020 In BOOT, boot_done=1 SHALL move the FSM to RELEASE; an external access in the same cycle SHALL still complete.
REQ-021 In RELEASE (exactly one cycle), cpu_hold=1, ext_ready=0 and mem_we=0; the next state SHALL be RUN.
REQ-022 In RUN, cpu_hold=0; with cpu_req=1 the CPU SHALL own the port and ext_ready=0.
REQ-023 In RUN with cpu_req=0 and ext_valid=1, ext SHALL be granted (ext_ready=1) and the starvation counter cleared.
REQ-024 In RUN, each cycle with ext_valid=1 and cpu_req=1 SHALL increment the starvation counter; reaching STARVE_MAX SHALL move the FSM to FORCE.
REQ-025 In FORCE (one cycle), cpu_stall=1, ext SHALL be granted unconditionally, the counter SHALL clear, and the next state SHALL be RUN.
REQ-026 ext_valid=0 SHALL clear the starvation counter; the counter SHALL saturate and never wrap.
REQ-027 A granted external read SHALL register mem_rdata into ext_rdata and pulse ext_rvalid exactly one cycle after the grant.
REQ-028 When neither side is granted, mem_we SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-029 Once RUN is reached, boot_done SHALL be ignored; only reset returns the FSM to BOOT.
REQ-030 An external request SHALL hold ext_* stable until ext_ready=1; the arbiter relies on this and does not buffer requests.

Reset
REQ-031 reset=0 SHALL asynchronously force BOOT, cpu_hold=1, cpu_stall=0, ext_ready=0, ext_rvalid=0, ext_rdata=0, counters=0, and mem_we=0.
REQ-032 A reset mid-RUN or mid-FORCE SHALL abort any pending grant; no write may occur in the reset cycle.

Configuration
REQ-033 With DMEM_ARB_STATS_EN defined, grant_cnt SHALL count external grants and force_cnt SHALL count FORCE entries, both 16-bit and saturating; without it, both outputs SHALL be tied to 0 and no counter logic synthesized.

Structure
REQ-034 The package dmem_arb_pkg SHALL hold the state enum (BOOT, RELEASE, RUN, FORCE) and the default STARVE_MAX and AW constants.
REQ-035 The starvation counter SHALL be a sub-module named dmem_arb_starve_ctr (inc/clear/saturate, done flag).

Verification
REQ-036 Boot load: three writes to addresses 0x0, 0x4 and 0x8 (data 0x11, 0x22, 0x33) with cpu_hold=1, then boot_done -> RELEASE for 1 cycle, then RUN with cpu_hold=0.
REQ-037 Idle-slot read: RUN, cpu_req=0, ext read at 0x4 -> ext_ready=1 the same cycle; ext_rvalid=1 with ext_rdata=0x22 the next cycle.
REQ-038 Starvation: cpu_req=1 continuously with ext_valid=1 -> FORCE after 8 cycles, cpu_stall=1 for exactly 1 cycle, ext granted, force_cnt=1 (with the stats macro).
REQ-039 Simultaneous event: boot_done=1 with an ext write of 0x44 to 0xC in BOOT -> write lands and the next state is RELEASE.
REQ-040 Async reset asserted in FORCE -> outputs reach their reset values before the next clk edge; no memory write occurs; FSM is in BOOT.
